// File: rtl/npc_ras_if.sv
// Next-PC unit bus: control/ALU inputs toward the PC unit and the
// PC / return-address-stack status coming back.
// There is no valid/ready pair: the unit consumes npcop/zero/imm/rd1 on every
// rising clk edge where stall is low, and its outputs are valid throughout.
interface npc_ras_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 26,
    parameter int CW    = 3
);
    logic             stall;
    logic [2:0]       npcop;
    logic             zero;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_4;
    logic [WIDTH-1:0] nextpc;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_err;

    // Control side: drives the operation and observes PC/RAS state.
    modport master (
        output stall, npcop, zero, imm, rd1,
        input  pc, pc_4, nextpc, ras_top, ras_count, ras_err
    );

    // PC unit side.
    modport slave (
        input  stall, npcop, zero, imm, rd1,
        output pc, pc_4, nextpc, ras_top, ras_count, ras_err
    );
endinterface

// File: rtl/npc_ras.sv
// Next-PC unit with architectural PC register and circular return-address
// stack. jal pushes pc+4, the RET op pops its target; a full stack overwrites
// its oldest entry and an empty-stack pop falls back to rd1, both latching
// the sticky ras_err flag.
module npc_ras #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          IMM_W     = 26,
    parameter int          RAS_DEPTH = 4,
    parameter int          CW        = $clog2(RAS_DEPTH + 1)
) (
    input logic         clk,
    input logic         rst,
    npc_ras_if.slave    bus
);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_BNE = 3'b010;
    localparam logic [2:0] OP_J   = 3'b011;
    localparam logic [2:0] OP_JAL = 3'b100;
    localparam logic [2:0] OP_JR  = 3'b101;
    localparam logic [2:0] OP_RET = 3'b110;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    wp_q;
    logic [CW-1:0]    count_q;
    logic             err_q;

    logic [WIDTH-1:0] pc_4;
    logic [WIDTH-1:0] boff;
    logic [WIDTH-1:0] jaddr;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nextpc;
    logic             push;
    logic             pop;
    logic             ras_empty;
    logic             ras_full;

    assign pc_4      = pc_q + WIDTH'(4);
    // Branch offset is relative to pc itself, not pc+4 (existing ISA convention).
    assign boff      = {{(WIDTH-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};
    assign jaddr     = {pc_q[WIDTH-1:IMM_W+2], bus.imm, 2'b00};
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CW'(RAS_DEPTH));
    assign top       = ras_empty ? '0 : ras_mem[wp_q - PW'(1)];

    // Decode npcop into the next PC and the RAS action for this cycle.
    always_comb begin
        nextpc = pc_4;
        push   = 1'b0;
        pop    = 1'b0;
        case (bus.npcop)
            OP_SEQ: nextpc = pc_4;
            OP_BEQ: nextpc = bus.zero ? pc_q + boff : pc_4;
            OP_BNE: nextpc = !bus.zero ? pc_q + boff : pc_4;
            OP_J:   nextpc = jaddr;
            OP_JAL: begin
                nextpc = jaddr;
                push   = 1'b1;
            end
            OP_JR:  nextpc = bus.rd1;
            OP_RET: begin
                nextpc = ras_empty ? bus.rd1 : top;
                pop    = 1'b1;
            end
            default: nextpc = pc_4;
        endcase
    end

    // PC and RAS state update; everything holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= WIDTH'(RESET_PC);
            wp_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!bus.stall) begin
            pc_q <= nextpc;
            if (push) begin
                ras_mem[wp_q] <= pc_4;
                wp_q          <= wp_q + PW'(1);
                if (ras_full) begin
                    // Oldest entry was just overwritten; count stays saturated.
                    err_q <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end else if (pop) begin
                if (ras_empty) begin
                    err_q <= 1'b1;
                end else begin
                    wp_q    <= wp_q - PW'(1);
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_4      = pc_4;
    assign bus.nextpc    = nextpc;
    assign bus.ras_top   = top;
    assign bus.ras_count = count_q;
    assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_npc_ras.sv
// Directed bench for npc_ras: sequential flow, branches, jal/return,
// RAS overflow wrap and underflow, stall, and asynchronous reset.
module tb_npc_ras;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    npc_ras_if #(.WIDTH(32), .IMM_W(26), .CW(3)) bus ();

    npc_ras #(
        .WIDTH(32), .RESET_PC(32'h0000_3000), .IMM_W(26), .RAS_DEPTH(4), .CW(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one operation and let combinational outputs settle.
    task automatic drive(input logic [2:0] op, input logic [25:0] imm,
                         input logic z, input logic [31:0] rd1, input logic st);
        bus.npcop = op;
        bus.imm   = imm;
        bus.zero  = z;
        bus.rd1   = rd1;
        bus.stall = st;
        #1;
    endtask

    // Advance one clock edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        drive(3'b000, 26'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) tick();
        check("rst_pc", bus.pc, 32'h3000);
        check("rst_pc4", bus.pc_4, 32'h3004);
        check("rst_top", bus.ras_top, 32'h0);
        check("rst_cnt", 32'(bus.ras_count), 32'd0);
        check("rst_err", 32'(bus.ras_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sequential
        tick(); check("seq1", bus.pc, 32'h3004);
        tick(); check("seq2", bus.pc, 32'h3008);
        tick(); check("seq3", bus.pc, 32'h300C);
        check("seq_cnt", 32'(bus.ras_count), 32'd0);
        check("seq_err", 32'(bus.ras_err), 32'd0);
        tick(); check("seq4", bus.pc, 32'h3010);

        // Branches from pc=0x3010
        drive(3'b001, 26'h000FFFC, 1'b0, 32'd0, 1'b0); check("beq_nt", bus.nextpc, 32'h3014);
        drive(3'b010, 26'h0000002, 1'b0, 32'd0, 1'b0); check("bne_t", bus.nextpc, 32'h3018);
        drive(3'b010, 26'h0000002, 1'b1, 32'd0, 1'b0); check("bne_nt", bus.nextpc, 32'h3014);
        drive(3'b101, 26'h0, 1'b0, 32'h0000_4444, 1'b0); check("jr", bus.nextpc, 32'h4444);
        drive(3'b111, 26'h0, 1'b1, 32'd0, 1'b0); check("op7", bus.nextpc, 32'h3014);
        drive(3'b001, 26'h000FFFC, 1'b1, 32'd0, 1'b0); check("beq_t", bus.nextpc, 32'h3000);
        tick(); check("beq_pc", bus.pc, 32'h3000);

        // J to 0x3020, then JAL / RET
        drive(3'b011, 26'h0000C08, 1'b0, 32'd0, 1'b0);
        tick(); check("j_pc", bus.pc, 32'h3020);
        drive(3'b100, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        tick();
        check("jal_pc", bus.pc, 32'h3040);
        check("jal_top", bus.ras_top, 32'h3024);
        check("jal_cnt", 32'(bus.ras_count), 32'd1);
        drive(3'b110, 26'h0, 1'b0, 32'h0000_DEAD, 1'b0);
        tick();
        check("ret_pc", bus.pc, 32'h3024);
        check("ret_cnt", 32'(bus.ras_count), 32'd0);
        check("ret_err", 32'(bus.ras_err), 32'd0);
        check("ret_top", bus.ras_top, 32'h0);

        // Stall during JAL
        drive(3'b100, 26'h0000C10, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stl_pc", bus.pc, 32'h3024);
            check("stl_cnt", 32'(bus.ras_count), 32'd0);
            check("stl_npc", bus.nextpc, 32'h3040);
        end
        drive(3'b100, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        tick();
        check("unstl_pc", bus.pc, 32'h3040);
        check("unstl_cnt", 32'(bus.ras_count), 32'd1);
        check("unstl_top", bus.ras_top, 32'h3028);
        drive(3'b000, 26'h0, 1'b0, 32'd0, 1'b0);
        tick();
        check("once_pc", bus.pc, 32'h3044);
        check("once_cnt", 32'(bus.ras_count), 32'd1);

        // Build count=2, pc=0x3040, then async reset between edges while stalled
        drive(3'b011, 26'h0000C0C, 1'b0, 32'd0, 1'b0);
        tick(); check("j2_pc", bus.pc, 32'h3030);
        drive(3'b100, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        tick();
        check("pre_pc", bus.pc, 32'h3040);
        check("pre_cnt", 32'(bus.ras_count), 32'd2);
        check("pre_top", bus.ras_top, 32'h3034);
        drive(3'b000, 26'h0, 1'b0, 32'd0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pc", bus.pc, 32'h3000);
        check("arst_cnt", 32'(bus.ras_count), 32'd0);
        check("arst_err", 32'(bus.ras_err), 32'd0);
        check("arst_top", bus.ras_top, 32'h0);
        check("arst_npc", bus.nextpc, 32'h3004);
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 26'h0, 1'b0, 32'd0, 1'b0);
        tick(); check("post_rst", bus.pc, 32'h3004);

        // Overflow: 5 chained JALs from P0..P4
        exp_q.delete();
        drive(3'b100, 26'h0000C40, 1'b0, 32'd0, 1'b0); exp_q.push_back(32'h3008); tick();
        drive(3'b100, 26'h0000C80, 1'b0, 32'd0, 1'b0); exp_q.push_back(32'h3104); tick();
        drive(3'b100, 26'h0000CC0, 1'b0, 32'd0, 1'b0); exp_q.push_back(32'h3204); tick();
        check("ovf_err0", 32'(bus.ras_err), 32'd0);
        drive(3'b100, 26'h0000D00, 1'b0, 32'd0, 1'b0); exp_q.push_back(32'h3304); tick();
        drive(3'b100, 26'h0000D40, 1'b0, 32'd0, 1'b0); exp_q.push_back(32'h3404); tick();
        check("ovf_pc", bus.pc, 32'h3500);
        check("ovf_cnt", 32'(bus.ras_count), 32'd4);
        check("ovf_err", 32'(bus.ras_err), 32'd1);
        void'(exp_q.pop_front());  // P0+4 is overwritten
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_back();
            drive(3'b110, 26'h0, 1'b0, 32'h0000_DEAD, 1'b0);
            check("pop_npc", bus.nextpc, exp_v);
            tick();
            check("pop_pc", bus.pc, exp_v);
            check("pop_cnt", 32'(bus.ras_count), 32'(3 - i));
        end
        drive(3'b110, 26'h0, 1'b0, 32'h0000_3100, 1'b0);
        check("unf_npc", bus.nextpc, 32'h3100);
        tick();
        check("unf_pc", bus.pc, 32'h3100);
        check("unf_cnt", 32'(bus.ras_count), 32'd0);
        check("unf_err", 32'(bus.ras_err), 32'd1);
        check("unf_top", bus.ras_top, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/npc_ras.md
Name: npc_ras

Overview:
- Next-generation next-PC unit. Owns the architectural PC register (async active-low reset to a parametrised vector) and computes the next PC for sequential, conditional-branch, jump, jump-and-link and register-jump flows.
- Adds a stall input and a return-address stack (RAS). `jal` pushes the return address; `jr $ra` pops its target from the stack.
- Sits between control/ALU (npcop, zero) and instruction memory (pc).

Parameters:
- WIDTH, 32, PC/data width; must be > IMM_W+2.
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMM_W, 26, jump-immediate width; branch offset is always imm[15:0].
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).
- CW, $clog2(RAS_DEPTH+1), width of ras_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  1 = hold PC and RAS this cycle.
- npcop  in  3  next-PC operation (encoding below).
- zero  in  1  ALU zero flag for branches.
- imm  in  IMM_W  instruction immediate field.
- rd1  in  WIDTH  register-file read data (jr target).
- pc  out  WIDTH  current PC (registered).
- pc_4  out  WIDTH  pc+4 (combinational; link value).
- nextpc  out  WIDTH  PC to be loaded at the next unstalled edge (combinational).
- ras_top  out  WIDTH  current top-of-stack entry (0 when empty).
- ras_count  out  CW  valid RAS entries, 0..RAS_DEPTH.
- ras_err  out  1  sticky: RAS overflow or underflow occurred since reset.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, ras_count=0, all RAS entries=0, write pointer=0, ras_err=0. Combinational outputs follow the reset state: pc_4=RESET_PC+4, ras_top=0.
- Arithmetic: modulo 2^WIDTH, no overflow detection.
- boff = sign-extend(imm[15:0]) << 2.
- jaddr = {pc[WIDTH-1:IMM_W+2], imm, 2'b00}.
- npcop decode (nextpc):
  - 000 SEQ → pc+4.
  - 001 BEQ → zero ? pc+boff : pc+4.
  - 010 BNE → !zero ? pc+boff : pc+4.
  - 011 J → jaddr.
  - 100 JAL → jaddr; push pc_4.
  - 101 JR → rd1; RAS untouched.
  - 110 RET → ras_count>0 ? ras_top : rd1; pop.
  - 111 → SEQ.
- Branch offset is added to pc, not pc+4. This is existing ISA convention, kept.
- Update: at a rising clk edge with rst=1 and stall=0: pc<=nextpc, then any RAS push/pop. With stall=1: pc, RAS, ras_count and ras_err all hold; nextpc is still computed.
- RAS is circular. Write pointer wp indexes the next free slot. Top = entry[wp-1 mod RAS_DEPTH].
- Push:
  - Write entry[wp]=pc_4 (the pre-update PC +4) and advance wp (wrap).
  - If ras_count<RAS_DEPTH, increment ras_count.
  - If ras_count==RAS_DEPTH, overwrite the oldest entry, leave ras_count saturated and set ras_err.
- Pop:
  - ras_count>0: retreat wp and decrement ras_count. Popped entries are not cleared.
  - ras_count==0: nextpc=rd1, wp and count unchanged, set ras_err.
- ras_top is 0 whenever ras_count==0.
- A single op never pushes and pops at once.
- rst asserted mid-stream (including during stall) returns all state to reset values immediately. The first edge after deassertion loads nextpc computed from RESET_PC.

Test Plan:
- Reset and sequential: hold rst=0, release, npcop=000 for 3 edges → pc 0x3000, 0x3004, 0x3008, 0x300C; ras_count=0, ras_err=0.
- Branches:
  - pc=0x3010, BEQ, imm=16'hFFFC, zero=1 → next pc 0x3000.
  - Same with zero=0 → 0x3014.
  - BNE, imm=16'h0002, zero=0 → pc+8.
- JAL/RET: pc=0x3020, JAL imm=26'h0000C10 → pc=0x3040, ras_top=0x3024, ras_count=1. Then RET with rd1=0xDEAD → pc=0x3024, ras_count=0, ras_err=0.
- Overflow wrap (RAS_DEPTH=4):
  - 5 JALs from pc values P0..P4 → ras_count=4, ras_err=1.
  - 4 RETs return P4+4, P3+4, P2+4, P1+4. P0+4 is lost.
  - A 5th RET with rd1=0x3100 → pc=0x3100, ras_count=0.
- Stall: during JAL with stall=1 for 2 cycles → pc, ras_count unchanged while nextpc shows the jump target. Releasing stall applies the jump and push once.
- Async reset mid-op: assert rst=0 between edges with ras_count=2, pc=0x3040 → pc=0x3000, ras_count=0, ras_err=0, ras_top=0 with no clock edge.
